// File: rtl/fd_pkg.sv
// ---------------------------------------------------------------------------
// fd_pkg
// Shared definitions for the fetch/decode control stage: FSM state encoding,
// supported RV32 opcodes, halt-cause codes, ALU control codes understood by
// the downstream datapath and an immediate sign-extension helper.
// ---------------------------------------------------------------------------
package fd_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      WB     = 3'd3,
      HALT   = 3'd4
   } fd_state_e;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;

   localparam logic [1:0] HC_NONE    = 2'b00;
   localparam logic [1:0] HC_ILLEGAL = 2'b01;
   localparam logic [1:0] HC_TIMEOUT = 2'b10;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;

   // Sign-extend a 12-bit I-type immediate to 32 bits.
   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// ---------------------------------------------------------------------------
// instr_decoder
// Purely combinational RV32 R-type / I-type ALU instruction decoder.
// Ports:
//   instr_i        instruction word
//   rs1_o, rs2_o   source register indices (rs2 forced to 0 for I-type)
//   rd_o           destination register index
//   alu_ctrl_o     ALU operation {funct7[5], funct3} style encoding
//   alu_src_imm_o  1 = operand B is the immediate
//   imm_o          sign-extended I-type immediate, 0 for R-type
//   legal_o        1 = opcode is supported
// ---------------------------------------------------------------------------
module instr_decoder
   import fd_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [4:0]  rd_o,
   output logic [3:0]  alu_ctrl_o,
   output logic        alu_src_imm_o,
   output logic [31:0] imm_o,
   output logic        legal_o
);

   logic [6:0] opcode_s;
   logic [2:0] funct3_s;

   assign opcode_s = instr_i[6:0];
   assign funct3_s = instr_i[14:12];

   // Map the instruction word onto datapath control fields.
   always_comb begin
      rs1_o         = instr_i[19:15];
      rd_o          = instr_i[11:7];
      rs2_o         = 5'd0;
      alu_ctrl_o    = ALU_ADD;
      alu_src_imm_o = 1'b0;
      imm_o         = 32'd0;
      legal_o       = 1'b0;
      case (opcode_s)
         OP_R: begin
            rs2_o      = instr_i[24:20];
            alu_ctrl_o = {instr_i[30], funct3_s};
            legal_o    = 1'b1;
         end
         OP_I: begin
            // Only the shift-right pair uses funct7[5] (SRLI vs SRAI); for the
            // other I-type ops those bits belong to the immediate.
            if (funct3_s == 3'b101) begin
               alu_ctrl_o = {instr_i[30], funct3_s};
            end else begin
               alu_ctrl_o = {1'b0, funct3_s};
            end
            alu_src_imm_o = 1'b1;
            imm_o         = sext12(instr_i[31:20]);
            legal_o       = 1'b1;
         end
         default: begin
            legal_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_decode_ctrl
// Multi-cycle fetch/decode control stage: FETCH -> DECODE -> EXEC -> WB,
// with a terminal HALT on illegal opcode or fetch timeout.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   imem_req/addr       instruction fetch request and byte address (= pc)
//   imem_valid/rdata    instruction return
//   stall               freezes the whole stage
//   mem_read_addr_1/2   rs1 / rs2 to register file
//   mem_write_addr      rd to register file
//   alu_ctrl            ALU operation
//   alu_src_imm, imm    immediate operand select and value
//   r_or_w              register write enable (WB only)
//   pc                  program counter
//   halted, halt_cause  sticky halt flag and reason
// ---------------------------------------------------------------------------
module fetch_decode_ctrl
   import fd_pkg::*;
#(
   parameter int unsigned     PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
   parameter int unsigned     WAIT_MAX = 15
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_valid,
   input  logic [31:0]     imem_rdata,
   input  logic            stall,
   output logic [4:0]      mem_read_addr_1,
   output logic [4:0]      mem_read_addr_2,
   output logic [4:0]      mem_write_addr,
   output logic [3:0]      alu_ctrl,
   output logic            alu_src_imm,
   output logic [31:0]     imm,
   output logic            r_or_w,
   output logic [PC_W-1:0] pc,
   output logic            halted,
   output logic [1:0]      halt_cause
);

   localparam int unsigned      WAIT_W    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

   fd_state_e         state_q;
   logic [PC_W-1:0]   pc_q;
   logic [PC_W-1:0]   pc_d;
   logic [31:0]       ir_q;
   logic [WAIT_W-1:0] wait_q;
   logic              req_q;
   logic [4:0]        rs1_q, rs2_q, rd_q;
   logic [3:0]        alu_q;
   logic              src_imm_q;
   logic [31:0]       imm_q;
   logic              wr_q;
   logic              halted_q;
   logic [1:0]        cause_q;

   logic [4:0]  dec_rs1_s, dec_rs2_s, dec_rd_s;
   logic [3:0]  dec_alu_s;
   logic        dec_src_imm_s;
   logic [31:0] dec_imm_s;
   logic        dec_legal_s;

   instr_decoder u_dec (
      .instr_i       (ir_q),
      .rs1_o         (dec_rs1_s),
      .rs2_o         (dec_rs2_s),
      .rd_o          (dec_rd_s),
      .alu_ctrl_o    (dec_alu_s),
      .alu_src_imm_o (dec_src_imm_s),
      .imm_o         (dec_imm_s),
      .legal_o       (dec_legal_s)
   );

   assign pc_d = pc_q + PC_W'(4);

   // Control FSM with all outputs registered; stall freezes every register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= 32'd0;
         wait_q    <= {WAIT_W{1'b0}};
         req_q     <= 1'b0;
         rs1_q     <= 5'd0;
         rs2_q     <= 5'd0;
         rd_q      <= 5'd0;
         alu_q     <= ALU_ADD;
         src_imm_q <= 1'b0;
         imm_q     <= 32'd0;
         wr_q      <= 1'b0;
         halted_q  <= 1'b0;
         cause_q   <= HC_NONE;
      end else if (!stall) begin
         case (state_q)
            FETCH: begin
               // The first FETCH cycle after entry only raises the request;
               // a word is accepted only while the request is visible.
               if (!req_q) begin
                  req_q <= 1'b1;
               end else if (imem_valid) begin
                  ir_q    <= imem_rdata;
                  req_q   <= 1'b0;
                  wait_q  <= {WAIT_W{1'b0}};
                  state_q <= DECODE;
               end else if (wait_q == WAIT_LAST) begin
                  req_q    <= 1'b0;
                  halted_q <= 1'b1;
                  cause_q  <= HC_TIMEOUT;
                  state_q  <= HALT;
               end else begin
                  wait_q <= wait_q + WAIT_W'(1);
               end
            end
            DECODE: begin
               if (dec_legal_s) begin
                  rs1_q     <= dec_rs1_s;
                  rs2_q     <= dec_rs2_s;
                  rd_q      <= dec_rd_s;
                  alu_q     <= dec_alu_s;
                  src_imm_q <= dec_src_imm_s;
                  imm_q     <= dec_imm_s;
                  state_q   <= EXEC;
               end else begin
                  halted_q <= 1'b1;
                  cause_q  <= HC_ILLEGAL;
                  state_q  <= HALT;
               end
            end
            EXEC: begin
               // Writes to x0 are suppressed at the source.
               wr_q    <= (rd_q != 5'd0);
               state_q <= WB;
            end
            WB: begin
               wr_q    <= 1'b0;
               pc_q    <= pc_d;
               req_q   <= 1'b1;
               state_q <= FETCH;
            end
            HALT: begin
               state_q <= HALT;
            end
            default: begin
               req_q    <= 1'b0;
               wr_q     <= 1'b0;
               halted_q <= 1'b1;
               state_q  <= HALT;
            end
         endcase
      end
   end

   assign imem_req        = req_q;
   assign imem_addr       = pc_q;
   assign pc              = pc_q;
   assign mem_read_addr_1 = rs1_q;
   assign mem_read_addr_2 = rs2_q;
   assign mem_write_addr  = rd_q;
   assign alu_ctrl        = alu_q;
   assign alu_src_imm     = src_imm_q;
   assign imm             = imm_q;
   assign r_or_w          = wr_q;
   assign halted          = halted_q;
   assign halt_cause      = cause_q;

endmodule

// File: doc/fetch_decode_ctrl.md
Name: fetch_decode_ctrl

Overview:
- Multi-cycle fetch/decode control stage that sits directly upstream of the register-file/ALU datapath.
- Fetches 32-bit RV32 instructions from an external instruction memory over a req/valid handshake.
- Decodes R-type and I-type ALU instructions and sequences the datapath's register read addresses, write address, ALU control, register write enable and immediate, one instruction at a time.
- Halts on any unsupported opcode.

Parameters:
- PC_W, 32, program counter width in bits; PC wraps modulo 2^PC_W.
- RESET_PC, 0, PC value loaded on reset.
- WAIT_MAX, 15, maximum cycles spent in FETCH waiting for imem_valid before the bus-error halt.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- imem_req  out  1  fetch request, held high until imem_valid.
- imem_addr  out  PC_W  byte address of the fetch, equals pc.
- imem_valid  in  1  instruction word valid this cycle.
- imem_rdata  in  32  instruction word.
- stall  in  1  freezes the FSM in its current state; all outputs hold.
- mem_read_addr_1  out  5  rs1 to datapath.
- mem_read_addr_2  out  5  rs2 to datapath; 0 for I-type.
- mem_write_addr  out  5  rd to datapath.
- alu_ctrl  out  4  ALU operation to datapath.
- alu_src_imm  out  1  1 = use imm as ALU operand B.
- imm  out  32  sign-extended I-type immediate; 0 for R-type.
- r_or_w  out  1  register write enable to datapath, asserted only in the WB state.
- pc  out  PC_W  current program counter.
- halted  out  1  sticky halt indicator.
- halt_cause  out  2  00 none, 01 illegal opcode, 10 fetch timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, pc=RESET_PC, and the instruction register cleared.
  - All decode outputs are 0; imem_req=0 for the first cycle after release, and halted=0, halt_cause=00.
- States:
  - FETCH -> DECODE -> EXEC -> WB -> FETCH.
  - HALT is terminal and is left only by reset.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - On imem_valid=1, latch imem_rdata into the instruction register and go to DECODE next cycle.
  - A wait counter increments each cycle without imem_valid. When it reaches WAIT_MAX, go to HALT with cause 10.
  - imem_valid while not in FETCH is ignored.
- DECODE: register opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
  - Opcode 0110011 (R-type): alu_ctrl={funct7[5],funct3}, alu_src_imm=0, imm=0. For example ADD=0000, SUB=1000, SLT=0010, SLTU=0011.
  - Opcode 0010011 (I-type): alu_ctrl={0,funct3}, except funct3=101 where alu_ctrl={funct7[5],101}. Also alu_src_imm=1, imm=sign-extended instr[31:20], and mem_read_addr_2=0.
  - Any other opcode: go to HALT, halt_cause=01, pc frozen at the faulting instruction.
- EXEC:
  - Decode outputs are stable for exactly one cycle with r_or_w=0. The datapath produces its result and zero flag in this cycle.
- WB:
  - r_or_w=1 for one cycle, except when rd=0, where r_or_w stays 0.
  - pc <= pc+4, modulo 2^PC_W.
  - Next state is FETCH.
- Latency: 4 cycles per instruction when imem_valid returns in the first FETCH cycle.
- Outputs are registered; decode outputs hold their last values through the WB and FETCH states.
- stall:
  - Takes priority over every transition and over the wait counter.
  - When asserted in WB, r_or_w stays high and pc does not advance until stall drops; the write happens once.
- HALT: imem_req=0, r_or_w=0, halted=1, and the other outputs hold.
- Reset mid-operation aborts immediately; a pending fetch is discarded.

Decomposition:
- Shared package fd_pkg:
  - State encoding localparams: FETCH, DECODE, EXEC, WB, HALT.
  - Opcode constants OP_R=0110011 and OP_I=0010011.
  - Halt-cause codes.
  - ALU control codes ALU_ADD=0000, ALU_SUB=1000, ALU_SLT=0010, ALU_SLTU=0011, matching the datapath.
- One sub-module, instr_decoder: purely combinational mapping from the instruction word to fields, alu_ctrl, imm and a legal flag. It is instantiated once and registered in DECODE.

Test Plan:
- Reset release with imem_valid tied high, imem_rdata=0x00A302B3 (add x5,x6,x10):
  - Cycle 3: mem_read_addr_1=6, mem_read_addr_2=10, mem_write_addr=5, alu_ctrl=0000.
  - Cycle 4: r_or_w=1.
  - Afterwards: pc=4.
- imem_rdata=0x40B50633 (sub x12,x10,x11): alu_ctrl=1000, alu_src_imm=0, r_or_w=1 in WB.
- imem_rdata=0xFFF28293 (addi x5,x5,-1): imm=0xFFFFFFFF, alu_src_imm=1, mem_read_addr_2=0.
- Instruction with rd=0 (0x00000033): r_or_w stays 0 throughout, and pc still increments by 4.
- imem_rdata=0x0000006F (jal): halted=1, halt_cause=01, pc unchanged, imem_req=0 thereafter.
- Hold imem_valid=0 for 20 cycles with default WAIT_MAX: halt_cause=10 after 15 cycles.
- Assert reset=0 mid-EXEC: outputs return to their reset values asynchronously, and the next fetch is from RESET_PC.
- stall=1 for 3 cycles during WB: r_or_w held high, pc advances once.
